// File: rtl/uart_pack_pkg.sv
// Shared definitions for the UART byte/word packing blocks (bytes_to_word, word_to_bytes).
// Holds the packer FSM encoding, the EOT byte value and the byte/word widths.
package uart_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [BYTE_W-1:0] EOT_DEFAULT = 8'h04;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2,
    EMIT     = 2'd3
  } pack_state_t;

  // Lane 0 is the MSB lane, so the first byte of a word lands in [31:24].
  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        lane,
                                                  input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bytes_to_word.sv
// Packs bytes from a UART receiver into 32-bit words, MSB lane first, with EOT-terminated
// short words and an inter-byte idle timeout that discards a stalled partial word.
module bytes_to_word
  import uart_pack_pkg::*;
#(
  parameter logic [BYTE_W-1:0] EOT_CHAR       = EOT_DEFAULT,
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_readable,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_used_tick,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [2:0]        word_bytes,
  output logic              word_last,
  output logic              msg_done_tick,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  // Word handshake: a word transfers on a rising edge where word_valid=1 and
  // word_ready=1; once raised, word_valid and the word fields hold until that edge,
  // and word_ready while word_valid=0 is ignored.

  pack_state_t       state, next_state;
  logic [BYTE_W-1:0] byte_reg;
  logic [WORD_W-1:0] word_reg;
  logic [2:0]        byte_idx;
  logic              last_reg;
  logic              emit_pend;
  logic [31:0]       idle_cnt;
  logic              is_eot;

  assign is_eot     = (byte_reg == EOT_CHAR);
  assign word_out   = word_reg;
  assign word_bytes = byte_idx;
  assign word_last  = last_reg;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    rx_used_tick  = 1'b0;
    msg_done_tick = 1'b0;
    word_valid    = 1'b0;
    case (state)
      COLLECT: begin
        if (rx_readable) next_state = ACK;
      end
      ACK: begin
        rx_used_tick  = 1'b1;
        msg_done_tick = is_eot;
        next_state    = WAIT_CLR;
      end
      WAIT_CLR: begin
        // The receiver must drop readable first, otherwise the same byte is read twice.
        if (!rx_readable) next_state = emit_pend ? EMIT : COLLECT;
      end
      EMIT: begin
        word_valid = 1'b1;
        if (word_ready) next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_reg    <= '0;
      word_reg    <= '0;
      byte_idx    <= '0;
      last_reg    <= 1'b0;
      emit_pend   <= 1'b0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (rx_readable) begin
            byte_reg <= rx_data;
            idle_cnt <= '0;
          end else if (byte_idx != 3'd0) begin
            if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
              timeout_err <= 1'b1;
              word_reg    <= '0;
              byte_idx    <= '0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        ACK: begin
          idle_cnt <= '0;
          if (is_eot) begin
            // Unused low lanes are already zero because the word starts cleared.
            if (byte_idx != 3'd0) begin
              last_reg  <= 1'b1;
              emit_pend <= 1'b1;
            end
          end else begin
            word_reg <= put_lane(word_reg, byte_idx[1:0], byte_reg);
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd3) emit_pend <= 1'b1;
          end
        end
        WAIT_CLR: begin
          idle_cnt <= '0;
        end
        EMIT: begin
          idle_cnt <= '0;
          if (word_ready) begin
            word_reg  <= '0;
            byte_idx  <= '0;
            last_reg  <= 1'b0;
            emit_pend <= 1'b0;
          end
        end
        default: idle_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bytes_to_word.sv
// Self-checking bench for bytes_to_word: directed scenarios plus randomized messages
// checked against a message-level packing model.
module tb_bytes_to_word;

  localparam logic [7:0] EOT = 8'h04;
  localparam int         TMO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_readable;
  logic [7:0]  rx_data;
  logic        rx_used_tick;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  word_bytes;
  logic        word_last;
  logic        msg_done_tick;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor tallies (written only by the monitor; tests take differences).
  int used_cnt     = 0;
  int done_cnt     = 0;
  int done_in_ack  = 0;
  int valid_cycles = 0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  bytes_to_word #(
    .EOT_CHAR      (EOT),
    .TIMEOUT_CYCLES(32'd50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_readable  (rx_readable),
    .rx_data      (rx_data),
    .rx_used_tick (rx_used_tick),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_bytes   (word_bytes),
    .word_last    (word_last),
    .msg_done_tick(msg_done_tick),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  always @(negedge clk) begin
    if (rx_used_tick) used_cnt++;
    if (msg_done_tick) done_cnt++;
    if (msg_done_tick && rx_used_tick) done_in_ack++;
    if (word_valid) valid_cycles++;
    if (word_valid && word_ready) got_q.push_back({word_last, word_bytes, word_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, finished=0 expected 1");
    $fatal(1, "watchdog");
  end

  // Message-level model: data bytes fill a word left to right; every 4 bytes make a
  // full word; EOT closes a non-empty partial word zero-padded on the right.
  function automatic void model_msg(input logic [7:0] b[$]);
    logic [31:0] acc;
    int          n;
    logic [2:0]  n3;
    acc = '0;
    n   = 0;
    foreach (b[i]) begin
      if (b[i] == EOT) begin
        if (n > 0) begin
          n3 = 3'(n);
          exp_q.push_back({1'b1, n3, acc});
        end
        acc = '0;
        n   = 0;
      end else begin
        acc = acc | (32'(b[i]) << (8 * (3 - n)));
        n++;
        if (n == 4) begin
          exp_q.push_back({1'b0, 3'd4, acc});
          acc = '0;
          n   = 0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] rand_data();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while (v == EOT) v = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Present a byte like the UART receiver: hold readable until the consume pulse,
  // then drop it on the following clock.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    rx_data     = b;
    rx_readable = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (rx_used_tick) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_byte: byte %h consumed=0 expected 1", b);
    end
    @(posedge clk); #1;
    rx_readable = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int calm;
    calm = 0;
    for (int k = 0; k < 500 && calm < 3; k++) begin
      @(negedge clk);
      if (!word_valid && dbg_state == 2'd0 && !rx_readable) calm++;
      else calm = 0;
    end
    n_checks++;
    if (calm < 3) begin
      n_fail++;
      $display("FAIL %s_quiet: state=%0d valid=%b expected state 0 valid 0", name, dbg_state, word_valid);
    end
  endtask

  task automatic check_words(input string name, input int base);
    int n_exp;
    n_exp = exp_q.size();
    n_checks++;
    if (got_q.size() - base != n_exp) begin
      n_fail++;
      $display("FAIL %s_count: words=%0d expected %0d", name, got_q.size() - base, n_exp);
    end
    for (int i = 0; i < n_exp && base + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[base + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_word%0d: {last,bytes,word}=%h expected %h", name, i, got_q[base + i], exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_readable = 1'b0; rx_data = '0; word_ready = 1'b0;
    #13;
    n_checks++;
    if ({rx_used_tick, word_out, word_valid, word_bytes, word_last, msg_done_tick, timeout_err} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: %h expected 0",
               {rx_used_tick, word_out, word_valid, word_bytes, word_last, msg_done_tick, timeout_err});
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: %0d expected 0", dbg_state);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_word();
    int base, u0, v0;
    logic [7:0] msg[$];
    msg = '{8'h55, 8'h33, 8'h0F, 8'h59};
    base = got_q.size(); u0 = used_cnt; v0 = valid_cycles;
    word_ready = 1'b1;
    foreach (msg[i]) send_byte(msg[i]);
    // Last byte: ACK, one WAIT_CLR cycle, then EMIT.
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_latency_early: valid=%b expected 0", word_valid);
    end
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency: valid=%b expected 1", word_valid);
    end
    wait_quiet("full");
    model_msg(msg);
    check_words("full", base);
    n_checks++;
    if (used_cnt - u0 != 4) begin
      n_fail++;
      $display("FAIL full_used_ticks: %0d expected 4", used_cnt - u0);
    end
    n_checks++;
    if (valid_cycles - v0 != 1) begin
      n_fail++;
      $display("FAIL full_valid_cycles: %0d expected 1", valid_cycles - v0);
    end
  endtask

  task automatic test_eot_partial();
    int base, d0, a0;
    logic [7:0] msg[$];
    msg = '{8'h9A, 8'h9A, EOT};
    base = got_q.size(); d0 = done_cnt; a0 = done_in_ack;
    word_ready = 1'b1;
    foreach (msg[i]) send_byte(msg[i]);
    wait_quiet("eot");
    model_msg(msg);
    check_words("eot", base);
    n_checks++;
    if (done_cnt - d0 != 1 || done_in_ack - a0 != 1) begin
      n_fail++;
      $display("FAIL eot_done_tick: pulses=%0d in_ack=%0d expected 1 1", done_cnt - d0, done_in_ack - a0);
    end
  endtask

  task automatic test_lone_eot();
    int base, d0, v0;
    base = got_q.size(); d0 = done_cnt; v0 = valid_cycles;
    word_ready = 1'b1;
    send_byte(EOT);
    wait_quiet("lone");
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL lone_done_tick: %0d expected 1", done_cnt - d0);
    end
    n_checks++;
    if (valid_cycles - v0 != 0 || got_q.size() != base) begin
      n_fail++;
      $display("FAIL lone_no_word: valid cycles=%0d expected 0", valid_cycles - v0);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int base, u0, bad, waited;
    logic [31:0] snap;
    logic [7:0] msg[$];
    for (int i = 0; i < 4; i++) msg.push_back(rand_data());
    base = got_q.size();
    word_ready = 1'b0;
    foreach (msg[i]) send_byte(msg[i]);
    waited = 0;
    while (!word_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!word_valid) begin
      n_fail++;
      $display("FAIL bp_valid: valid=%b expected 1", word_valid);
    end
    snap = word_out;
    u0   = used_cnt;
    bad  = 0;
    fork
      send_byte(8'hAA);
    join_none
    repeat (20) begin
      @(negedge clk);
      if (word_out !== snap || word_valid !== 1'b1 || word_bytes !== 3'd4) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: unstable cycles=%0d expected 0", bad);
    end
    n_checks++;
    if (used_cnt != u0) begin
      n_fail++;
      $display("FAIL bp_no_consume: used ticks=%0d expected 0", used_cnt - u0);
    end
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait fork;
    send_byte(EOT);
    wait_quiet("bp");
    msg.push_back(8'hAA);
    msg.push_back(EOT);
    model_msg(msg);
    check_words("bp", base);
  endtask

  task automatic test_random();
    int base, u0, total;
    bit drv_done;
    logic [7:0] stream[$];
    for (int m = 0; m < 6; m++) begin
      int len;
      len = $urandom_range(0, 9);
      for (int j = 0; j < len; j++) stream.push_back(rand_data());
      stream.push_back(EOT);
    end
    total = stream.size();
    model_msg(stream);
    base = got_q.size(); u0 = used_cnt;
    drv_done = 0;
    fork
      begin
        foreach (stream[i]) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send_byte(stream[i]);
        end
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          word_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_quiet("rand");
    check_words("rand", base);
    n_checks++;
    if (used_cnt - u0 != total) begin
      n_fail++;
      $display("FAIL rand_used_ticks: %0d expected %0d", used_cnt - u0, total);
    end
  endtask

  task automatic test_timeout();
    int base, rise;
    logic [7:0] msg[$];
    word_ready = 1'b1;
    send_byte(rand_data());
    // Counted from the consume pulse: ACK and WAIT_CLR, then TMO idle COLLECT cycles.
    rise = -1;
    for (int k = 1; k <= 200 && rise < 0; k++) begin
      @(negedge clk);
      if (timeout_err) rise = k;
    end
    n_checks++;
    if (rise != TMO + 2) begin
      n_fail++;
      $display("FAIL timeout_rise: cycle=%0d expected %0d", rise, TMO + 2);
    end
    base = got_q.size();
    for (int i = 0; i < 4; i++) msg.push_back(rand_data());
    foreach (msg[i]) send_byte(msg[i]);
    wait_quiet("tmo");
    model_msg(msg);
    check_words("tmo", base);
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: %b expected 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] msg[$];
    word_ready = 1'b1;
    send_byte(rand_data());
    send_byte(rand_data());
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rx_used_tick, word_out, word_valid, word_bytes, word_last, msg_done_tick, timeout_err} !== 39'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: %h expected 0",
               {rx_used_tick, word_out, word_valid, word_bytes, word_last, msg_done_tick, timeout_err});
    end
    @(negedge clk); rst = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 4; i++) msg.push_back(rand_data());
    foreach (msg[i]) send_byte(msg[i]);
    wait_quiet("rst_mid");
    model_msg(msg);
    check_words("rst_mid", base);

    // Reset while a full word is pending in EMIT.
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(rand_data());
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (word_valid !== 1'b0 || word_out !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_emit_outputs: valid=%b word=%h expected 0 0", word_valid, word_out);
    end
    @(negedge clk); rst = 1'b1;
    base = got_q.size();
    @(posedge clk); #1;
    word_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (got_q.size() != base) begin
      n_fail++;
      $display("FAIL rst_emit_dropped: words=%0d expected 0", got_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_eot_partial();
    test_lone_eot();
    test_back_to_back_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
